// File: rtl/fetch_decode_queue.sv
// rtl/fetch_decode_queue.sv - fetch-to-decode instruction queue with capture handshake, ecall block and flush
// Optional same-cycle fetch->decode bypass when IFQ_BYPASS_EN is defined.
module fetch_decode_queue #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_done,
  input  logic [XLEN-1:0]          fetch_pc,
  input  logic [XLEN-1:0]          fetch_data,
  output logic                     fetch_latched,
  input  logic                     flush,
  output logic                     dec_valid,
  input  logic                     dec_ready,
  output logic [31:0]              dec_instr,
  output logic [XLEN-1:0]          dec_pc,
  output logic                     ecall_seen,
  input  logic                     ecall_clear,
  output logic [$clog2(DEPTH):0]   q_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {ACCEPT, HANDOFF} state_t;
  state_t state_q, state_d;

  logic [31:0]     instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;

  logic [31:0] sel_instr;
  logic        q_empty, q_full, push, pop_q, store, bypass;

  assign sel_instr = fetch_pc[2] ? fetch_data[63:32] : fetch_data[31:0];
  assign q_empty   = (q_count == '0);
  assign q_full    = (q_count == CW'(DEPTH));
  // Full test uses the registered count, so a same-cycle pop never frees a slot for a push.
  assign push      = (state_q == ACCEPT) && fetch_done && !q_full && !ecall_seen && !flush;
  assign pop_q     = !q_empty && dec_ready;

`ifdef IFQ_BYPASS_EN
  assign bypass = q_empty && push && dec_ready;
`else
  assign bypass = 1'b0;
`endif

  assign store     = push && !bypass;
  assign dec_valid = !q_empty || bypass;
  assign dec_instr = bypass ? sel_instr : instr_mem[rd_ptr];
  assign dec_pc    = bypass ? fetch_pc  : pc_mem[rd_ptr];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCEPT:  if (push) state_d = HANDOFF;
      HANDOFF: state_d = ACCEPT;
      default: state_d = ACCEPT;
    endcase
    if (flush) state_d = ACCEPT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ACCEPT;
      fetch_latched <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      q_count       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else begin
      state_q       <= state_d;
      fetch_latched <= push;
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        q_count <= '0;
      end else begin
        if (store) begin
          instr_mem[wr_ptr] <= sel_instr;
          pc_mem[wr_ptr]    <= fetch_pc;
          wr_ptr            <= wr_ptr + AW'(1);
        end
        if (pop_q) rd_ptr <= rd_ptr + AW'(1);
        if (store && !pop_q)      q_count <= q_count + CW'(1);
        else if (!store && pop_q) q_count <= q_count - CW'(1);
      end
    end
  end

  // Set beats clear; flush leaves the flag alone.
  always_ff @(posedge clk) begin
    if (reset)                                 ecall_seen <= 1'b0;
    else if (push && sel_instr == 32'h00000073) ecall_seen <= 1'b1;
    else if (ecall_clear)                      ecall_seen <= 1'b0;
  end
endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb/tb_fetch_decode_queue.sv - randomized and directed checks of fetch_decode_queue against a queue model
module tb_fetch_decode_queue;
  localparam int DEPTH = 2;
  localparam int XLEN  = 64;

  logic            clk = 1'b0;
  logic            reset, fetch_done, flush, dec_ready, ecall_clear;
  logic [XLEN-1:0] fetch_pc, fetch_data, dec_pc;
  logic            fetch_latched, dec_valid, ecall_seen;
  logic [31:0]     dec_instr;
  logic [$clog2(DEPTH):0] q_count;

  fetch_decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .fetch_done(fetch_done), .fetch_pc(fetch_pc),
    .fetch_data(fetch_data), .fetch_latched(fetch_latched), .flush(flush),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
    .dec_pc(dec_pc), .ecall_seen(ecall_seen), .ecall_clear(ecall_clear),
    .q_count(q_count)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] instr; logic [63:0] pc;} entry_t;
  entry_t m_q[$];
  logic   m_latched, m_ecall;
  int     n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle against the model, then advance the model.
  task automatic cycle(input logic fd, input logic [63:0] pc, input logic [63:0] d,
                       input logic rdy, input logic fl, input logic ec, input logic rst);
    logic [31:0] ins;
    logic        accept, byp;
    entry_t      e;
    fetch_done = fd; fetch_pc = pc; fetch_data = d;
    dec_ready = rdy; flush = fl; ecall_clear = ec; reset = rst;
    @(negedge clk);
    ins    = pc[2] ? d[63:32] : d[31:0];
    accept = fd && (m_q.size() != DEPTH) && !m_ecall && !m_latched && !fl;
    byp    = 1'b0;
`ifdef IFQ_BYPASS_EN
    byp    = accept && rdy && (m_q.size() == 0);
`endif
    check("q_count", 64'(q_count), 64'(m_q.size()));
    check("fetch_latched", 64'(fetch_latched), 64'(m_latched));
    check("ecall_seen", 64'(ecall_seen), 64'(m_ecall));
    check("dec_valid", 64'(dec_valid), 64'((m_q.size() != 0) || byp));
    if (byp) begin
      check("dec_instr_byp", 64'(dec_instr), 64'(ins));
      check("dec_pc_byp", dec_pc, pc);
    end else if (m_q.size() != 0) begin
      check("dec_instr", 64'(dec_instr), 64'(m_q[0].instr));
      check("dec_pc", dec_pc, m_q[0].pc);
    end
    if (rst) begin
      m_q.delete(); m_latched = 1'b0; m_ecall = 1'b0;
    end else begin
      if (fl) m_q.delete();
      else begin
        if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
        if (accept && !byp) begin
          e.instr = ins; e.pc = pc; m_q.push_back(e);
        end
      end
      if (accept && ins == 32'h00000073) m_ecall = 1'b1;
      else if (ec)                       m_ecall = 1'b0;
      m_latched = accept;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 64'h0, 64'h0, rdy, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [63:0] pc, d, base;
    logic [31:0] w;
    int          k;
    reset = 1'b1; fetch_done = 1'b0; fetch_pc = '0; fetch_data = '0;
    dec_ready = 1'b0; flush = 1'b0; ecall_clear = 1'b0;
    m_latched = 1'b0; m_ecall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_q_count", 64'(q_count), 64'd0);
    check("rst_dec_valid", 64'(dec_valid), 64'd0);
    check("rst_dec_instr", 64'(dec_instr), 64'd0);
    check("rst_dec_pc", dec_pc, 64'd0);
    check("rst_latched", 64'(fetch_latched), 64'd0);
    check("rst_ecall", 64'(ecall_seen), 64'd0);

    // fetch of upper word, visible to decode next cycle
    cycle(1'b1, 64'h1004, 64'h00A00093_00500113, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t1_latched", 64'(fetch_latched), 64'd1);
    check("t1_instr", 64'(dec_instr), 64'h00A00093);
    check("t1_pc", dec_pc, 64'h1004);
    idle(1'b0);
    check("t1_pulse_end", 64'(fetch_latched), 64'd0);

    // back-to-back offers against a stalled decoder; fetcher holds pc until latched
    cycle(1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    pc = 64'h0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, pc, {32'h00000013, 32'h00100093}, i >= 5, 1'b0, 1'b0, 1'b0);
      if (m_latched) pc = pc + 64'h4;
      if (i == 4) check("t2_full", 64'(q_count), 64'd2);
    end

    // ecall blocks capture until cleared
    cycle(1'b0, 64'h0, 64'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 64'h2000, 64'h00000013_00000073, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t3_ecall", 64'(ecall_seen), 64'd1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 64'h2004, 64'h00000013_00000013, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'h2004, 64'h00000013_00000013, 1'b1, 1'b0, 1'b1, 1'b0);
    k = 0;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 64'h2004, 64'h00000013_00000013, 1'b1, 1'b0, 1'b0, 1'b0);
      if (fetch_latched) k++;
    end
    check("t3_relatched", 64'(k), 64'd1);

    // flush with simultaneous fetch at full
    cycle(1'b0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 64'h100, 64'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    cycle(1'b1, 64'h104, 64'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'h108, 64'h3, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t4_count", 64'(q_count), 64'd0);
    check("t4_latched", 64'(fetch_latched), 64'd0);

    // push and pop together at count 1
    cycle(1'b1, 64'h200, 64'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    cycle(1'b1, 64'h20C, 64'h00000022_00000000, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t5_count", 64'(q_count), 64'd1);
    check("t5_head", dec_pc, 64'h20C);

    // randomized traffic
    base = 64'h8000_0000;
    for (int i = 0; i < 4000; i++) begin
      d = {$urandom, $urandom};
      w = 32'h00000073;
      if ($urandom_range(11) == 0) d[31:0]  = w;
      if ($urandom_range(11) == 0) d[63:32] = w;
      pc = base + 64'($urandom_range(63));
      cycle($urandom_range(9) < 7, pc, d, $urandom_range(1) == 1,
            $urandom_range(15) == 0, $urandom_range(5) == 0, $urandom_range(199) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
